sw_word_loader: RTL and testbench
=================================

// Module: sw_word_loader
// PURPOSE
//  Front-panel input path. Builds two 32-bit words, byte by byte, from 8 slide switches.
//  A debounced push-button loads each byte. The byte lane map matches the LED byte-display
//  select: lanes 0-3 are douta[7:0]..[31:24], lanes 4-7 are doutb[7:0]..[31:24].
//  It feeds the ALU/CPU operand registers and pulses a valid flag when a word is complete.
// PARAMETERS
//  DEB_CYCLES  500000  consecutive stable cycles to accept a button level change (10 ms @ 50 MHz)
//  CNT_W       20      debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   synchronous, active-high reset
//  btn      in   1   raw, asynchronous load push-button (1 = pressed)
//  sw       in   8   byte value to load
//  sel      in   3   target byte lane (0-3 word A, 4-7 word B)
//  douta    out  32  assembled word A
//  doutb    out  32  assembled word B
//  valid_a  out  1   1-cycle pulse: all 4 bytes of A written since last pulse/reset
//  valid_b  out  1   1-cycle pulse: same for B
//  lane     out  3   lane the next load will write
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): douta=doutb=0, valid_a=valid_b=0, lane=0, byte masks=0,
//    sync flops=0, debounced level btn_db=0, debounce counter=0. Reset overrides every other action.
//  - Sync: btn passes through 2 flops (btn_s). The first edge that samples btn=1 is edge 1.
//  - Debounce: counter increments each cycle btn_s != btn_db and clears each cycle they are equal.
//    When btn_s != btn_db with counter == DEB_CYCLES-1, btn_db takes btn_s and the counter clears.
//    Glitches shorter than DEB_CYCLES cycles produce no change.
//  - load_stb (internal) = btn_db rose this cycle; exactly 1 cycle per accepted press.
//    Release produces no strobe.
//  - Load, on the edge after load_stb: sw is written to the byte of lane sampled in the load_stb
//    cycle; all other bytes hold. A clean press updates the output at edge DEB_CYCLES+3.
//  - Byte masks mask_a/mask_b[3:0]: a write sets the lane bit. Rewriting a set byte overwrites
//    the data and leaves the mask unchanged.
//  - If a write makes a mask 4'hF: on that same edge the mask clears and valid_x goes 1 for one
//    cycle, coincident with the final byte appearing on dout_x. Only one word is written per load,
//    so valid_a and valid_b never pulse together.
//  - sel may change at any time; only its value in the load_stb cycle matters.
//  - Holding btn through reset: btn_db restarts at 0, so one load occurs DEB_CYCLES+3 edges after
//    rst deasserts.
//  - Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  BYTE_AUTO_INC_EN defined:
//   - sel is ignored; lane is an internal pointer.
//   - After each load, lane increments and wraps 7->0 (fill A lanes 0-3, then B lanes 4-7).
//   - Reset sets lane=0.
//  BYTE_AUTO_INC_EN undefined:
//   - lane = registered copy of sel, updated every cycle; no pointer logic.
// TESTING (bench uses DEB_CYCLES=4)
//  1 Reset then idle 20 cycles -> douta=doutb=0, valid_a=valid_b=0, lane=0.
//  2 sel=2, sw=8'hA5, btn held 10 cycles -> douta=32'h00A5_0000 at edge 7; exactly one write;
//    no valid pulse.
//  3 btn glitch high 3 cycles, sel=0 -> no btn_db change; douta unchanged.
//  4 Press for lanes 0..3 with sw=11,22,33,44 -> douta=32'h4433_2211; valid_a high 1 cycle on
//    the 4th write; masks clear; a 5th press to lane 0 gives no pulse.
//  5 Lane 5 written twice (sw=AA then BB), then lanes 4,6,7 -> doutb[15:8]=BB; valid_b pulses
//    only after lane 7.
//  6 rst during a counting debounce -> all outputs 0; held btn gives one load at edge 7 after
//    rst low. With BYTE_AUTO_INC_EN, 8 presses -> lane sequence 0..7,0; valid_a and valid_b
//    each pulse once.

Source files
------------

// File: rtl/sw_word_loader_if.sv
// Front-panel bus between the switch/button panel and sw_word_loader.
// The panel side (master) drives btn/sw/sel and the loader (slave) returns
// the assembled words, the word-complete pulses and the current lane.
interface sw_word_loader_if;
    logic        btn;
    logic [7:0]  sw;
    logic [2:0]  sel;
    logic [31:0] douta;
    logic [31:0] doutb;
    logic        valid_a;
    logic        valid_b;
    logic [2:0]  lane;

    modport master (
        output btn, sw, sel,
        input  douta, doutb, valid_a, valid_b, lane
    );

    modport slave (
        input  btn, sw, sel,
        output douta, doutb, valid_a, valid_b, lane
    );
endinterface

// File: rtl/sw_word_loader.sv
// sw_word_loader: builds two 32-bit words byte by byte from 8 slide switches.
// A debounced push-button loads sw into the byte lane sel (lanes 0-3 -> douta,
// lanes 4-7 -> doutb). valid_a/valid_b pulse once when all four bytes of a word
// have been written since the previous pulse or reset.
// Optional feature macro: BYTE_AUTO_INC_EN -- sel is ignored and the lane is an
// internal pointer that advances after every load and wraps 7->0.
module sw_word_loader #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    sw_word_loader_if.slave   bus
);

    logic             sync1_q, sync1_d;
    logic             btn_s_q, btn_s_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_db_prev_q, btn_db_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      douta_q, douta_d;
    logic [31:0]      doutb_q, doutb_d;
    logic [3:0]       mask_a_q, mask_a_d;
    logic [3:0]       mask_b_q, mask_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic [2:0]       lane_q, lane_d;

    logic             load_stb;
    logic [2:0]       wr_lane;
    logic [3:0]       mask_new;

    // Two-flop synchroniser for the asynchronous button.
    always_comb begin
        sync1_d = bus.btn;
        btn_s_d = sync1_q;
    end

    // Debounce: accept a level change only after DEB_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        btn_db_d      = btn_db_q;
        cnt_d         = '0;
        btn_db_prev_d = btn_db_q;
        if (btn_s_q != btn_db_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                btn_db_d = btn_s_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // One strobe per accepted press; release produces none.
    assign load_stb = btn_db_q & ~btn_db_prev_q;

`ifdef BYTE_AUTO_INC_EN
    assign wr_lane = lane_q;
`else
    assign wr_lane = bus.sel;
`endif

    // Byte write, mask tracking and word-complete pulse generation.
    always_comb begin
        douta_d   = douta_q;
        doutb_d   = doutb_q;
        mask_a_d  = mask_a_q;
        mask_b_d  = mask_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        mask_new  = 4'h0;
        if (load_stb) begin
            if (!wr_lane[2]) begin
                douta_d[{wr_lane[1:0], 3'b000} +: 8] = bus.sw;
                mask_new = mask_a_q | (4'b0001 << wr_lane[1:0]);
                if (mask_new == 4'hF) begin
                    mask_a_d  = 4'h0;
                    valid_a_d = 1'b1;
                end else begin
                    mask_a_d = mask_new;
                end
            end else begin
                doutb_d[{wr_lane[1:0], 3'b000} +: 8] = bus.sw;
                mask_new = mask_b_q | (4'b0001 << wr_lane[1:0]);
                if (mask_new == 4'hF) begin
                    mask_b_d  = 4'h0;
                    valid_b_d = 1'b1;
                end else begin
                    mask_b_d = mask_new;
                end
            end
        end
    end

    // Lane report: pointer that advances per load, or a registered copy of sel.
    always_comb begin
`ifdef BYTE_AUTO_INC_EN
        lane_d = load_stb ? lane_q + 3'd1 : lane_q;
`else
        lane_d = bus.sel;
`endif
    end

    // State register; reset overrides every other action.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            cnt_q         <= '0;
            douta_q       <= 32'h0;
            doutb_q       <= 32'h0;
            mask_a_q      <= 4'h0;
            mask_b_q      <= 4'h0;
            valid_a_q     <= 1'b0;
            valid_b_q     <= 1'b0;
            lane_q        <= 3'd0;
        end else begin
            sync1_q       <= sync1_d;
            btn_s_q       <= btn_s_d;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_prev_d;
            cnt_q         <= cnt_d;
            douta_q       <= douta_d;
            doutb_q       <= doutb_d;
            mask_a_q      <= mask_a_d;
            mask_b_q      <= mask_b_d;
            valid_a_q     <= valid_a_d;
            valid_b_q     <= valid_b_d;
            lane_q        <= lane_d;
        end
    end

    assign bus.douta   = douta_q;
    assign bus.doutb   = doutb_q;
    assign bus.valid_a = valid_a_q;
    assign bus.valid_b = valid_b_q;
    assign bus.lane    = lane_q;

endmodule

// File: tb/tb_sw_word_loader.sv
// Directed bench for sw_word_loader with DEB_CYCLES=4: reset/idle, press
// latency, glitch rejection, a table of presses with expected words/pulses,
// and reset during a debounce with the button held.
module tb_sw_word_loader;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sw_word_loader_if bus();

    sw_word_loader #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  sw;
        logic [31:0] ea;
        logic [31:0] eb;
        int          eva;
        int          evb;
        logic [2:0]  elane;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Press for 10 cycles, release for 10; count valid pulses and capture
    // the word visible in the pulse cycle.
    task automatic press(input logic [2:0] s, input logic [7:0] v,
                         output int va, output int vb,
                         output logic [31:0] cap_a, output logic [31:0] cap_b);
        va = 0; vb = 0; cap_a = '0; cap_b = '0;
        @(negedge clk);
        bus.sel = s;
        bus.sw  = v;
        bus.btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_a) begin va++; cap_a = bus.douta; end
            if (bus.valid_b) begin vb++; cap_b = bus.doutb; end
            if (e == 10) bus.btn = 1'b0;
        end
    endtask

    initial begin
        int          va, vb, changes;
        logic [31:0] cap_a, cap_b, prev;
        logic [31:0] exp2, exp6;

        rst = 1'b1; bus.btn = 1'b0; bus.sw = 8'h00; bus.sel = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        va = 0; vb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.valid_a) va++;
            if (bus.valid_b) vb++;
        end
        chk("reset_douta", bus.douta, 32'h0);
        chk("reset_doutb", bus.doutb, 32'h0);
        chk("reset_lane", {29'h0, bus.lane}, 32'h0);
        chk("reset_valid_a", va, 0);
        chk("reset_valid_b", vb, 0);

        // 2: latency of a clean press
`ifdef BYTE_AUTO_INC_EN
        exp2 = 32'h0000_00A5;
`else
        exp2 = 32'h00A5_0000;
`endif
        @(negedge clk);
        bus.sel = 3'd2; bus.sw = 8'hA5; bus.btn = 1'b1;
        prev = bus.douta; changes = 0; va = 0; vb = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (bus.douta !== prev) changes++;
            prev = bus.douta;
            if (bus.valid_a) va++;
            if (bus.valid_b) vb++;
            if (e == 6) chk("press_edge6", bus.douta, 32'h0);
            if (e == 7) chk("press_edge7", bus.douta, exp2);
            if (e == 10) bus.btn = 1'b0;
        end
        chk("press_one_write", changes, 1);
        chk("press_no_valid", va + vb, 0);

        // 3: 3-cycle glitch must be rejected
        @(negedge clk);
        bus.sel = 3'd0; bus.sw = 8'hFF; bus.btn = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("glitch_douta", bus.douta, exp2);
        chk("glitch_btn_db", {31'h0, dut.btn_db_q}, 32'h0);

        // 4/5: table of presses
`ifdef BYTE_AUTO_INC_EN
        do_reset();
        tbl.push_back('{3'd7, 8'h01, 32'h0000_0001, 32'h0, 0, 0, 3'd1});
        tbl.push_back('{3'd7, 8'h02, 32'h0000_0201, 32'h0, 0, 0, 3'd2});
        tbl.push_back('{3'd7, 8'h03, 32'h0003_0201, 32'h0, 0, 0, 3'd3});
        tbl.push_back('{3'd7, 8'h04, 32'h0403_0201, 32'h0, 1, 0, 3'd4});
        tbl.push_back('{3'd0, 8'h05, 32'h0403_0201, 32'h0000_0005, 0, 0, 3'd5});
        tbl.push_back('{3'd0, 8'h06, 32'h0403_0201, 32'h0000_0605, 0, 0, 3'd6});
        tbl.push_back('{3'd0, 8'h07, 32'h0403_0201, 32'h0007_0605, 0, 0, 3'd7});
        tbl.push_back('{3'd0, 8'h08, 32'h0403_0201, 32'h0807_0605, 0, 1, 3'd0});
`else
        tbl.push_back('{3'd0, 8'h11, 32'h00A5_0011, 32'h0, 0, 0, 3'd0});
        tbl.push_back('{3'd1, 8'h22, 32'h00A5_2211, 32'h0, 0, 0, 3'd1});
        tbl.push_back('{3'd2, 8'h33, 32'h0033_2211, 32'h0, 0, 0, 3'd2});
        tbl.push_back('{3'd3, 8'h44, 32'h4433_2211, 32'h0, 1, 0, 3'd3});
        tbl.push_back('{3'd0, 8'h55, 32'h4433_2255, 32'h0, 0, 0, 3'd0});
        tbl.push_back('{3'd5, 8'hAA, 32'h4433_2255, 32'h0000_AA00, 0, 0, 3'd5});
        tbl.push_back('{3'd5, 8'hBB, 32'h4433_2255, 32'h0000_BB00, 0, 0, 3'd5});
        tbl.push_back('{3'd4, 8'h01, 32'h4433_2255, 32'h0000_BB01, 0, 0, 3'd4});
        tbl.push_back('{3'd6, 8'h02, 32'h4433_2255, 32'h0002_BB01, 0, 0, 3'd6});
        tbl.push_back('{3'd7, 8'h03, 32'h4433_2255, 32'h0302_BB01, 0, 1, 3'd7});
`endif
        foreach (tbl[i]) begin
            press(tbl[i].sel, tbl[i].sw, va, vb, cap_a, cap_b);
            chk($sformatf("vec%0d_douta", i), bus.douta, tbl[i].ea);
            chk($sformatf("vec%0d_doutb", i), bus.doutb, tbl[i].eb);
            chk($sformatf("vec%0d_valid_a", i), va, tbl[i].eva);
            chk($sformatf("vec%0d_valid_b", i), vb, tbl[i].evb);
            chk($sformatf("vec%0d_lane", i), {29'h0, bus.lane}, {29'h0, tbl[i].elane});
            if (va != 0) chk($sformatf("vec%0d_pulse_word_a", i), cap_a, tbl[i].ea);
            if (vb != 0) chk($sformatf("vec%0d_pulse_word_b", i), cap_b, tbl[i].eb);
        end

        // 6: reset during a counting debounce, button held throughout
`ifdef BYTE_AUTO_INC_EN
        exp6 = 32'h0000_0077;
`else
        exp6 = 32'h0000_7700;
`endif
        @(negedge clk);
        bus.sel = 3'd1; bus.sw = 8'h77; bus.btn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_douta", bus.douta, 32'h0);
        chk("rst_mid_doutb", bus.doutb, 32'h0);
        chk("rst_mid_lane", {29'h0, bus.lane}, 32'h0);
        chk("rst_mid_valid", {30'h0, bus.valid_a, bus.valid_b}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 6) chk("rst_held_edge6", bus.douta, 32'h0);
            if (e == 7) chk("rst_held_edge7", bus.douta, exp6);
        end
        bus.btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_held_final", bus.douta, exp6);
        chk("rst_held_lane", {29'h0, bus.lane}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
